// File: rtl/servo_pwm_generator.sv
// Single-channel RC servo/ESC PWM transmitter. A clamped command is staged in
// a shadow register and applied glitch-free at frame boundaries, with failsafe on timeout.
module servo_pwm_generator #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned FRAME_US       = 20000,
  parameter int unsigned MIN_US         = 1000,
  parameter int unsigned MAX_US         = 2000,
  parameter int unsigned FAILSAFE_US    = 1500,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [11:0] CMD_WIDTH,
  output logic        PWM_OUT,
  output logic        FRAME_START,
  output logic        FAILSAFE,
  output logic        CLAMPED
);

  localparam int unsigned TICKS_PER_US = CLK_HZ / 1000000;
  localparam int unsigned PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int unsigned US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int unsigned CMP_W = (US_W > 12) ? US_W : 12;
  localparam int unsigned TMO_W = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_FRAMES);
  localparam logic [11:0]      MIN_W    = 12'(MIN_US);
  localparam logic [11:0]      MAX_W    = 12'(MAX_US);
  localparam logic [11:0]      FS_W     = 12'(FAILSAFE_US);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [US_W-1:0]  us_q, us_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [11:0]      active_q, active_d;
  logic [11:0]      shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             pwm_q, pwm_d;
  logic             frame_start_q, frame_start_d;
  logic             failsafe_q, failsafe_d;
  logic             clamped_q, clamped_d;

  logic             boundary;
  logic             accept;
  logic [11:0]      cmd_clamped;
  logic             cmd_out_of_range;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pre_q         <= '0;
      us_q          <= '0;
      tmo_q         <= '0;
      active_q      <= FS_W;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      failsafe_q    <= 1'b1;
      clamped_q     <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      us_q          <= us_d;
      tmo_q         <= tmo_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      failsafe_q    <= failsafe_d;
      clamped_q     <= clamped_d;
    end
  end

  always_comb begin
    boundary = (pre_q == '0) && (us_q == '0);
    accept   = CMD_VALID && !shadow_full_q;

    cmd_clamped      = CMD_WIDTH;
    cmd_out_of_range = 1'b0;
    if (CMD_WIDTH < MIN_W) begin
      cmd_clamped      = MIN_W;
      cmd_out_of_range = 1'b1;
    end else if (CMD_WIDTH > MAX_W) begin
      cmd_clamped      = MAX_W;
      cmd_out_of_range = 1'b1;
    end
  end

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    us_d  = us_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      us_d  = (us_q == US_LAST) ? '0 : us_q + US_W'(1);
    end
  end

  // Shadow is only loadable when empty, so acceptance and apply never coincide;
  // an acceptance in a boundary cycle waits for the following boundary.
  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    failsafe_d    = failsafe_q;
    clamped_d     = clamped_q;
    tmo_d         = tmo_q;

    if (boundary && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
      failsafe_d    = 1'b0;
    end else if (boundary && (tmo_q == TMO_MAX)) begin
      active_d   = FS_W;
      failsafe_d = 1'b1;
    end

    if (accept) begin
      shadow_d      = cmd_clamped;
      shadow_full_d = 1'b1;
      clamped_d     = cmd_out_of_range;
      tmo_d         = '0;
    end else if (boundary && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Compare against the width the current frame will use, so the pulse starts with FRAME_START.
  always_comb begin
    frame_start_d = boundary;
    pwm_d         = CMP_W'(us_q) < CMP_W'(active_d);
  end

  assign CMD_READY   = ~shadow_full_q;
  assign PWM_OUT     = pwm_q;
  assign FRAME_START = frame_start_q;
  assign FAILSAFE    = failsafe_q;
  assign CLAMPED     = clamped_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Self-checking bench for servo_pwm_generator using a scaled-down timebase:
// 2 ticks/us, 100 us frame, 10..20 us range, 15 us failsafe, 3-frame timeout.
module tb_servo_pwm_generator;

  localparam int unsigned CLK_HZ    = 2000000;
  localparam int unsigned TICKS     = 2;
  localparam int unsigned FRAME_US  = 100;
  localparam int unsigned FRAME_CYC = FRAME_US * TICKS;
  localparam int unsigned FS_US     = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_width = '0;
  logic        pwm_out;
  logic        frame_start;
  logic        failsafe;
  logic        clamped;

  servo_pwm_generator #(
    .CLK_HZ        (CLK_HZ),
    .FRAME_US      (FRAME_US),
    .MIN_US        (10),
    .MAX_US        (20),
    .FAILSAFE_US   (FS_US),
    .TIMEOUT_FRAMES(3)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_WIDTH  (cmd_width),
    .PWM_OUT    (pwm_out),
    .FRAME_START(frame_start),
    .FAILSAFE   (failsafe),
    .CLAMPED    (clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cmd;
    bit          clamp;
    int unsigned us;
  } vec_t;

  typedef struct {
    int unsigned cycles;
    bit          fs;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Frame monitor: measures each completed frame and pops its expectation.
  int unsigned hi_cnt;
  bit          in_frame = 1'b0;
  bit          fs_at_start, seen_low, rerise;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (frame_start) begin
      if (in_frame) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_unexpected: got frame of %0d cycles, want no frame", hi_cnt);
        end else begin
          e = exp_q.pop_front();
          if (hi_cnt != e.cycles || fs_at_start != e.fs || rerise) begin
            miscompares++;
            $display("FAIL frame_pulse: got %0d cycles failsafe=%0b rerise=%0b, want %0d cycles failsafe=%0b",
                     hi_cnt, fs_at_start, rerise, e.cycles, e.fs);
          end
        end
      end
      in_frame    = 1'b1;
      hi_cnt      = pwm_out ? 1 : 0;
      fs_at_start = failsafe;
      seen_low    = !pwm_out;
      rerise      = 1'b0;
    end else if (in_frame) begin
      if (pwm_out) begin
        hi_cnt++;
        if (seen_low) rerise = 1'b1;
      end else begin
        seen_low = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * FRAME_CYC + 4);
    vectors++;
    if (!frame_start) begin
      miscompares++;
      $display("FAIL fs_timeout: got no FRAME_START in %0d cycles, want one", n);
    end
  endtask

  task automatic frame(input int unsigned us, input bit fs);
    int n;
    exp_t x;
    wait_fs(n);
    x.cycles = us * TICKS;
    x.fs     = fs;
    exp_q.push_back(x);
  endtask

  task automatic send(input int unsigned k, input logic [11:0] w, input bit exp_clamp);
    repeat (k) @(negedge clk);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_width = w;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_drop", int'(cmd_ready), 0);
    chk("clamped", int'(clamped), int'(exp_clamp));
  endtask

  initial begin
    int n;
    exp_t x;
    vecs[0] = '{12'd12,   1'b0, 12};
    vecs[1] = '{12'd5,    1'b1, 10};
    vecs[2] = '{12'd30,   1'b1, 20};
    vecs[3] = '{12'd18,   1'b0, 18};
    vecs[4] = '{12'd0,    1'b1, 10};
    vecs[5] = '{12'd4095, 1'b1, 20};
    vecs[6] = '{12'd10,   1'b0, 10};
    vecs[7] = '{12'd20,   1'b0, 20};
    vecs[8] = '{12'd9,    1'b1, 10};
    vecs[9] = '{12'd21,   1'b1, 20};

    repeat (3) @(negedge clk);
    chk("rst_pwm",      int'(pwm_out),     0);
    chk("rst_fs_pulse", int'(frame_start), 0);
    chk("rst_ready",    int'(cmd_ready),   1);
    chk("rst_failsafe", int'(failsafe),    1);
    chk("rst_clamped",  int'(clamped),     0);
    rst = 1'b0;

    wait_fs(n);
    chk("first_fs_latency", n, 1);
    x.cycles = FS_US * TICKS;
    x.fs     = 1'b1;
    exp_q.push_back(x);

    // Mid-frame commands apply at the next boundary; current frame unchanged.
    for (int unsigned i = 0; i < 10; i++) begin
      send(5, vecs[i].cmd, vecs[i].clamp);
      frame(vecs[i].us, 1'b0);
      chk("ready_after_apply", int'(cmd_ready), 1);
    end

    // Command held exactly in the boundary cycle with the shadow empty.
    repeat (FRAME_CYC - 1) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_width = 12'd17;
    frame(20, 1'b0);
    cmd_valid = 1'b0;
    chk("simul_accepted", int'(cmd_ready), 0);
    chk("simul_clamped",  int'(clamped),   0);
    frame(17, 1'b0);

    // No further commands: timeout then failsafe, then recovery.
    frame(17, 1'b0);
    frame(17, 1'b0);
    frame(FS_US, 1'b1);
    send(5, 12'd11, 1'b0);
    frame(11, 1'b0);

    // Reset during a pulse with a pending shadow command.
    send(5, 12'd18, 1'b0);
    frame(18, 1'b0);
    send(1, 12'd13, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pwm",      int'(pwm_out),   0);
    chk("async_rst_ready",    int'(cmd_ready), 1);
    chk("async_rst_failsafe", int'(failsafe),  1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fs(n);
    chk("post_rst_fs_latency", n, 1);
    x.cycles = FS_US * TICKS;
    x.fs     = 1'b1;
    exp_q.push_back(x);
    frame(FS_US, 1'b1);
    wait_fs(n);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
